// File: rtl/vx_om_ds_unit.sv
// Depth/stencil test stage of the OM pipeline: two-stage elastic pipe producing pass flag,
// new depth/stencil and write masks. Define OM_DS_STATS_EN to add pass/fail perf counters.
package vx_om_ds_pkg;

   typedef enum logic [2:0] {
      CMP_NEVER    = 3'd0,
      CMP_LESS     = 3'd1,
      CMP_EQUAL    = 3'd2,
      CMP_LEQUAL   = 3'd3,
      CMP_GREATER  = 3'd4,
      CMP_NOTEQUAL = 3'd5,
      CMP_GEQUAL   = 3'd6,
      CMP_ALWAYS   = 3'd7
   } om_cmp_e;

   typedef enum logic [2:0] {
      SOP_KEEP      = 3'd0,
      SOP_ZERO      = 3'd1,
      SOP_REPLACE   = 3'd2,
      SOP_INCR      = 3'd3,
      SOP_DECR      = 3'd4,
      SOP_INVERT    = 3'd5,
      SOP_INCR_WRAP = 3'd6,
      SOP_DECR_WRAP = 3'd7
   } om_sop_e;

   // Two-entry arrays are indexed by face: 0 = front, 1 = back.
   typedef struct packed {
      logic            depth_enable;
      logic [2:0]      depth_func;
      logic            depth_writemask;
      logic [1:0]      stencil_enable;
      logic [1:0][2:0] stencil_func;
      logic [1:0][2:0] stencil_zpass;
      logic [1:0][2:0] stencil_zfail;
      logic [1:0][2:0] stencil_fail;
      logic [1:0][7:0] stencil_ref;
      logic [1:0][7:0] stencil_mask;
      logic [1:0][7:0] stencil_writemask;
   } om_dcrs_t;

endpackage

module vx_om_ds_unit
   import vx_om_ds_pkg::*;
#(
   parameter string       INSTANCE_ID = "",
   parameter int unsigned TAG_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  om_dcrs_t             om_dcrs,
   input  logic                 valid_in,
   output logic                 ready_in,
   input  logic [TAG_WIDTH-1:0] tag_in,
   input  logic                 face_in,
   input  logic [23:0]          depth_in,
   input  logic [23:0]          depth_val,
   input  logic [7:0]           stencil_val,
   output logic                 valid_out,
   input  logic                 ready_out,
   output logic [TAG_WIDTH-1:0] tag_out,
   output logic                 pass_out,
   output logic [23:0]          depth_out,
   output logic                 depth_wmask,
   output logic [7:0]           stencil_out,
   output logic [7:0]           stencil_wmask
`ifdef OM_DS_STATS_EN
   ,
   output logic [31:0]          perf_pass_count,
   output logic [31:0]          perf_fail_count
`endif
);

   function automatic logic cmp_pass(input logic [2:0] func, input logic [23:0] a,
                                     input logic [23:0] b);
      logic r;
      r = 1'b0;
      case (om_cmp_e'(func))
         CMP_NEVER:    r = 1'b0;
         CMP_LESS:     r = (a <  b);
         CMP_EQUAL:    r = (a == b);
         CMP_LEQUAL:   r = (a <= b);
         CMP_GREATER:  r = (a >  b);
         CMP_NOTEQUAL: r = (a != b);
         CMP_GEQUAL:   r = (a >= b);
         CMP_ALWAYS:   r = 1'b1;
         default:      r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] sop_apply(input logic [2:0] op, input logic [7:0] v,
                                            input logic [7:0] refv);
      logic [7:0] r;
      r = v;
      case (om_sop_e'(op))
         SOP_KEEP:      r = v;
         SOP_ZERO:      r = '0;
         SOP_REPLACE:   r = refv;
         SOP_INCR:      r = (v == 8'hFF) ? 8'hFF : v + 8'd1;
         SOP_DECR:      r = (v == 8'h00) ? 8'h00 : v - 8'd1;
         SOP_INVERT:    r = ~v;
         SOP_INCR_WRAP: r = v + 8'd1;
         SOP_DECR_WRAP: r = v - 8'd1;
         default:       r = v;
      endcase
      return r;
   endfunction

   // Stage 0: fragment plus the face-selected DCR fields captured at input fire.
   logic                 s0_valid;
   logic [TAG_WIDTH-1:0] s0_tag;
   logic [23:0]          s0_depth;
   logic [23:0]          s0_depth_val;
   logic [7:0]           s0_sval;
   logic [7:0]           s0_ref;
   logic [7:0]           s0_mask;
   logic [7:0]           s0_wm;
   logic [2:0]           s0_sfunc;
   logic [2:0]           s0_op_fail;
   logic [2:0]           s0_op_zfail;
   logic [2:0]           s0_op_zpass;
   logic                 s0_senable;
   logic                 s0_denable;
   logic [2:0]           s0_dfunc;
   logic                 s0_dwritemask;

   logic                 s1_valid;
   logic [TAG_WIDTH-1:0] s1_tag;
   logic                 s1_spass;
   logic                 s1_dpass;
   logic [23:0]          s1_depth;
   logic [7:0]           s1_sval;
   logic [7:0]           s1_ref;
   logic [7:0]           s1_wm;
   logic [2:0]           s1_op;
   logic                 s1_senable;
   logic                 s1_dwe;

   logic                 s1_ready;
   logic                 in_fire;
   logic                 s0_advance;
   logic                 s0_spass;
   logic                 s0_dpass;
   logic [2:0]           s0_op;
   logic [7:0]           s1_new;

   assign s1_ready   = ~s1_valid | ready_out;
   assign s0_advance = s0_valid & s1_ready;
   assign ready_in   = ~s0_valid | s1_ready;
   assign in_fire    = valid_in & ready_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_valid <= 1'b0;
      end else if (ready_in) begin
         s0_valid <= valid_in;
      end
      if (in_fire) begin
         s0_tag        <= tag_in;
         s0_depth      <= depth_in;
         s0_depth_val  <= depth_val;
         s0_sval       <= stencil_val;
         s0_ref        <= om_dcrs.stencil_ref[face_in];
         s0_mask       <= om_dcrs.stencil_mask[face_in];
         s0_wm         <= om_dcrs.stencil_writemask[face_in];
         s0_sfunc      <= om_dcrs.stencil_func[face_in];
         s0_op_fail    <= om_dcrs.stencil_fail[face_in];
         s0_op_zfail   <= om_dcrs.stencil_zfail[face_in];
         s0_op_zpass   <= om_dcrs.stencil_zpass[face_in];
         s0_senable    <= om_dcrs.stencil_enable[face_in];
         s0_denable    <= om_dcrs.depth_enable;
         s0_dfunc      <= om_dcrs.depth_func;
         s0_dwritemask <= om_dcrs.depth_writemask;
      end
   end

   always_comb begin
      s0_spass = ~s0_senable
               | cmp_pass(s0_sfunc, {16'h0, s0_ref & s0_mask}, {16'h0, s0_sval & s0_mask});
      s0_dpass = ~s0_denable | cmp_pass(s0_dfunc, s0_depth, s0_depth_val);
      if (~s0_spass) begin
         s0_op = s0_op_fail;
      end else if (~s0_dpass) begin
         s0_op = s0_op_zfail;
      end else begin
         s0_op = s0_op_zpass;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (s1_ready) begin
         s1_valid <= s0_valid;
      end
      if (s0_advance) begin
         s1_tag     <= s0_tag;
         s1_spass   <= s0_spass;
         s1_dpass   <= s0_dpass;
         s1_depth   <= s0_depth;
         s1_sval    <= s0_sval;
         s1_ref     <= s0_ref;
         s1_wm      <= s0_wm;
         s1_op      <= s0_op;
         s1_senable <= s0_senable;
         s1_dwe     <= s0_denable & s0_dwritemask;
      end
   end

   assign s1_new        = sop_apply(s1_op, s1_sval, s1_ref);
   assign valid_out     = s1_valid;
   assign tag_out       = s1_tag;
   assign pass_out      = s1_spass & s1_dpass;
   assign depth_out     = s1_depth;
   assign depth_wmask   = s1_dwe & s1_spass & s1_dpass;
   assign stencil_out   = (s1_new & s1_wm) | (s1_sval & ~s1_wm);
   assign stencil_wmask = s1_senable ? s1_wm : '0;

`ifdef OM_DS_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_pass_count <= '0;
         perf_fail_count <= '0;
      end else if (valid_out & ready_out) begin
         if (pass_out) begin
            perf_pass_count <= perf_pass_count + 32'd1;
         end else begin
            perf_fail_count <= perf_fail_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vx_om_ds_unit.sv
// Self-checking bench for vx_om_ds_unit: queue-based reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_vx_om_ds_unit;
   import vx_om_ds_pkg::*;

   typedef struct {
      logic [7:0]  tag;
      logic        pass;
      logic [23:0] depth;
      logic        dwm;
      logic [7:0]  sout;
      logic [7:0]  swm;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   om_dcrs_t    om_dcrs = '0;
   logic        valid_in = 1'b0;
   logic        ready_in;
   logic [7:0]  tag_in = '0;
   logic        face_in = 1'b0;
   logic [23:0] depth_in = '0;
   logic [23:0] depth_val = '0;
   logic [7:0]  stencil_val = '0;
   logic        valid_out;
   logic        ready_out = 1'b1;
   logic [7:0]  tag_out;
   logic        pass_out;
   logic [23:0] depth_out;
   logic        depth_wmask;
   logic [7:0]  stencil_out;
   logic [7:0]  stencil_wmask;
`ifdef OM_DS_STATS_EN
   logic [31:0] perf_pass_count;
   logic [31:0] perf_fail_count;
`endif

   int   n_checks = 0;
   int   n_fail = 0;
   int   rmode = 0;
   exp_t q[$];
   int   m_pass = 0;
   int   m_fail = 0;

   vx_om_ds_unit #(.INSTANCE_ID("ds"), .TAG_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .om_dcrs(om_dcrs),
      .valid_in(valid_in), .ready_in(ready_in), .tag_in(tag_in), .face_in(face_in),
      .depth_in(depth_in), .depth_val(depth_val), .stencil_val(stencil_val),
      .valid_out(valid_out), .ready_out(ready_out), .tag_out(tag_out), .pass_out(pass_out),
      .depth_out(depth_out), .depth_wmask(depth_wmask), .stencil_out(stencil_out),
      .stencil_wmask(stencil_wmask)
`ifdef OM_DS_STATS_EN
      , .perf_pass_count(perf_pass_count), .perf_fail_count(perf_fail_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic bit rel(input int f, input longint a, input longint b);
      case (f)
         0: return 1'b0;
         1: return a < b;
         2: return a == b;
         3: return a <= b;
         4: return a > b;
         5: return a != b;
         6: return a >= b;
         default: return 1'b1;
      endcase
   endfunction

   function automatic exp_t model(input om_dcrs_t d, input logic face, input logic [7:0] tag,
                                  input logic [23:0] z, input logic [23:0] zv,
                                  input logic [7:0] sv);
      exp_t e;
      int s, m, r, wm, st, nv, op;
      bit sp, dp;
      s  = face ? 1 : 0;
      m  = int'(d.stencil_mask[s]);
      r  = int'(d.stencil_ref[s]);
      wm = int'(d.stencil_writemask[s]);
      st = int'(sv);
      sp = !d.stencil_enable[s] || rel(int'(d.stencil_func[s]), longint'(r & m), longint'(st & m));
      dp = !d.depth_enable || rel(int'(d.depth_func), longint'(z), longint'(zv));
      if (!sp)      op = int'(d.stencil_fail[s]);
      else if (!dp) op = int'(d.stencil_zfail[s]);
      else          op = int'(d.stencil_zpass[s]);
      case (op)
         0: nv = st;
         1: nv = 0;
         2: nv = r;
         3: nv = (st == 255) ? 255 : st + 1;
         4: nv = (st == 0) ? 0 : st - 1;
         5: nv = 255 - st;
         6: nv = (st + 1) % 256;
         default: nv = (st + 255) % 256;
      endcase
      e.tag   = tag;
      e.pass  = sp && dp;
      e.depth = z;
      e.dwm   = d.depth_enable && d.depth_writemask && sp && dp;
      e.sout  = 8'((nv & wm) | (st & (255 - wm)));
      e.swm   = d.stencil_enable[s] ? 8'(wm) : 8'h00;
      return e;
   endfunction

   // Downstream ready pattern: 0 always, 1 toggle, 2 mostly ready, 3 stalled.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: ready_out = 1'b1;
            1: ready_out = ~ready_out;
            2: ready_out = ($urandom_range(0, 3) != 0);
            default: ready_out = 1'b0;
         endcase
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            q.delete();
            m_pass = 0;
            m_fail = 0;
         end else begin
`ifdef OM_DS_STATS_EN
            chk("perf_pass", perf_pass_count, 32'(m_pass));
            chk("perf_fail", perf_fail_count, 32'(m_fail));
`endif
            if (valid_out) begin
               if (q.size() == 0) begin
                  chk("spurious_valid_out", 32'(valid_out), 32'd0);
               end else begin
                  e = q[0];
                  chk("tag_out", 32'(tag_out), 32'(e.tag));
                  chk("pass_out", 32'(pass_out), 32'(e.pass));
                  chk("depth_out", 32'(depth_out), 32'(e.depth));
                  chk("depth_wmask", 32'(depth_wmask), 32'(e.dwm));
                  chk("stencil_out", 32'(stencil_out), 32'(e.sout));
                  chk("stencil_wmask", 32'(stencil_wmask), 32'(e.swm));
                  if (ready_out) begin
                     void'(q.pop_front());
                     if (e.pass) m_pass++; else m_fail++;
                  end
               end
            end
            if (valid_in && ready_in)
               q.push_back(model(om_dcrs, face_in, tag_in, depth_in, depth_val, stencil_val));
         end
      end
   end

   task automatic send(input logic [7:0] tag, input logic face, input logic [23:0] z,
                       input logic [23:0] zv, input logic [7:0] sv);
      bit ok;
      ok = 1'b0;
      tag_in = tag; face_in = face; depth_in = z; depth_val = zv; stencil_val = sv;
      valid_in = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (ready_in) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_wait", 32'(ok), 32'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (q.size() == 0 && !valid_out) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain_wait", 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic pin(input string nm, input exp_t e, input logic p, input logic [7:0] so,
                      input logic [7:0] swm, input logic dwm);
      chk({nm, "_pass"}, 32'(e.pass), 32'(p));
      chk({nm, "_sout"}, 32'(e.sout), 32'(so));
      chk({nm, "_swm"}, 32'(e.swm), 32'(swm));
      chk({nm, "_dwm"}, 32'(e.dwm), 32'(dwm));
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      om_dcrs_t    d;
      logic [95:0] raw;
      logic [7:0]  sv_sat[4];
      logic [2:0]  op_sat[4];
      logic [7:0]  so_sat[4];

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_valid_out", 32'(valid_out), 32'd0);
      chk("reset_ready_in", 32'(ready_in), 32'd1);
      @(posedge clk); #1;

      // Directed: depth LESS, stencil disabled
      d = '0;
      d.depth_enable = 1'b1; d.depth_func = 3'd1; d.depth_writemask = 1'b1;
      om_dcrs = d;
      pin("t1", model(d, 1'b0, 8'h01, 24'h100, 24'h200, 8'h00), 1'b1, 8'h00, 8'h00, 1'b1);
      send(8'h01, 1'b0, 24'h100, 24'h200, 8'h00);

      // Directed: stencil EQUAL, zpass INCR, depth ALWAYS without write
      d = '0;
      d.depth_enable = 1'b1; d.depth_func = 3'd7; d.depth_writemask = 1'b0;
      d.stencil_enable[0] = 1'b1; d.stencil_func[0] = 3'd2; d.stencil_ref[0] = 8'd5;
      d.stencil_mask[0] = 8'hFF; d.stencil_zpass[0] = 3'd3; d.stencil_writemask[0] = 8'hFF;
      om_dcrs = d;
      pin("t2", model(d, 1'b0, 8'h02, 24'h1, 24'h2, 8'd5), 1'b1, 8'd6, 8'hFF, 1'b0);
      send(8'h02, 1'b0, 24'h1, 24'h2, 8'd5);

      // Directed: back face, stencil NEVER, fail REPLACE under partial write mask
      d = '0;
      d.stencil_enable[1] = 1'b1; d.stencil_func[1] = 3'd0; d.stencil_fail[1] = 3'd2;
      d.stencil_ref[1] = 8'hA5; d.stencil_mask[1] = 8'hFF; d.stencil_writemask[1] = 8'h0F;
      om_dcrs = d;
      pin("t3", model(d, 1'b1, 8'h03, 24'h5, 24'h5, 8'h33), 1'b0, 8'h35, 8'h0F, 1'b0);
      send(8'h03, 1'b1, 24'h5, 24'h5, 8'h33);

      // Saturation and wrap boundaries through the zpass op
      sv_sat = '{8'hFF, 8'hFF, 8'h00, 8'h00};
      op_sat = '{3'd3, 3'd6, 3'd4, 3'd7};
      so_sat = '{8'hFF, 8'h00, 8'h00, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         d = '0;
         d.stencil_enable[0] = 1'b1; d.stencil_func[0] = 3'd7;
         d.stencil_zpass[0] = op_sat[i]; d.stencil_writemask[0] = 8'hFF;
         om_dcrs = d;
         pin($sformatf("sat%0d", i), model(d, 1'b0, 8'(8'h10 + i), 24'h0, 24'h0, sv_sat[i]),
             1'b1, so_sat[i], 8'hFF, 1'b0);
         send(8'(8'h10 + i), 1'b0, 24'h0, 24'h0, sv_sat[i]);
      end
      drain();

      // Backpressure with toggling ready and a mid-stream depth_func rewrite
      rmode = 1;
      d = '0;
      d.depth_enable = 1'b1; d.depth_func = 3'd1; d.depth_writemask = 1'b1;
      om_dcrs = d;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) om_dcrs.depth_func = 3'd4;
         send(8'(8'h80 + i), 1'b0, 24'(i * 16), 24'h30, 8'(i));
      end
      drain();

      // Full pipe stalled: input must be refused, then accepted once drained
      rmode = 3;
      repeat (2) @(posedge clk);
      #1;
      send(8'h90, 1'b0, 24'h1, 24'h2, 8'h1);
      send(8'h91, 1'b1, 24'h3, 24'h2, 8'h2);
      tag_in = 8'h92; valid_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("full_ready_in", 32'(ready_in), 32'd0);
      chk("full_valid_out", 32'(valid_out), 32'd1);
      @(posedge clk); #1;
      rmode = 0;
      send(8'h92, 1'b0, 24'h7, 24'h7, 8'h3);
      drain();

      // Reset with two fragments in flight
      rmode = 3;
      repeat (2) @(posedge clk);
      #1;
      send(8'hA0, 1'b0, 24'h1, 24'h1, 8'h1);
      send(8'hA1, 1'b0, 24'h2, 24'h1, 8'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      rmode = 0;
      @(negedge clk);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_ready_in", 32'(ready_in), 32'd1);
`ifdef OM_DS_STATS_EN
      chk("rst_perf_pass", perf_pass_count, 32'd0);
      chk("rst_perf_fail", perf_fail_count, 32'd0);
`endif
      @(posedge clk); #1;

      // Randomized traffic with random DCRs per fragment
      rmode = 2;
      for (int i = 0; i < 300; i++) begin
         raw = {$urandom(), $urandom(), $urandom()};
         om_dcrs = om_dcrs_t'(raw[$bits(om_dcrs_t)-1:0]);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
         begin
            logic [23:0] zv, z;
            logic [7:0]  sv;
            zv = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 7)) : 24'($urandom());
            z  = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 7)) : 24'($urandom());
            case ($urandom_range(0, 3))
               0: sv = 8'h00;
               1: sv = 8'hFF;
               default: sv = 8'($urandom());
            endcase
            send(8'(i), 1'($urandom()), z, zv, sv);
         end
      end
      rmode = 0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
